receptor_pacote: RTL and testbench

Sensor-response packet receiver sitting between `uart_rx` and the arbiter FSM. It accepts bytes from the UART receiver and assembles each two-byte sensor answer. It checks the answer's XOR checksum and enforces an answer window after each request and an inter-byte gap limit. It reports exactly one outcome per armed window to the arbiter: valid data, checksum error, framing error or timeout.

---
 rtl/receptor_pacote.sv | 178 +++++++++++++++++
 tb/tb_receptor_pacote.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_pacote.sv
// Two-byte sensor answer receiver: {data, data^key} framing, answer window and inter-byte gap checks.
// Optional unsolicited-packet alarm path enabled by defining RECEPTOR_ALARM_EN.
module receptor_pacote #(
  parameter int unsigned CLKS_TIMEOUT  = 500_000_000,
  parameter int unsigned CLKS_BYTE_GAP = 100_000,
  parameter logic [7:0]  CHECKSUM_KEY  = 8'h37
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_busy,
  output logic [7:0]  o_data,
  output logic [15:0] o_packet,
  output logic        o_valid,
  output logic        o_cksum_err,
  output logic        o_frame_err,
  output logic        o_timeout,
  output logic        o_alarm
);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_WAIT_FIRST  = 2'd1;
  localparam logic [1:0] S_WAIT_SECOND = 2'd2;
  localparam logic [1:0] S_CHECK       = 2'd3;

  // Counter holds (cycles spent in state - 1), so expiry is flagged one below the limit.
  localparam logic [31:0] TIMEOUT_LAST = 32'(CLKS_TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST     = 32'(CLKS_BYTE_GAP - 1);

  logic [1:0]  state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next, cnt_sat;
  logic [7:0]  d_reg, d_next;
  logic [7:0]  c_reg, c_next;
  logic        unsol_reg, unsol_next;
  logic        busy_reg, busy_next;
  logic [7:0]  data_reg, data_next;
  logic [15:0] packet_reg, packet_next;
  logic        valid_reg, valid_next;
  logic        cksum_reg, cksum_next;
  logic        frame_reg, frame_next;
  logic        timeout_reg, timeout_next;
  logic        good;
`ifdef RECEPTOR_ALARM_EN
  logic        alarm_reg, alarm_next;
`endif

  assign cnt_sat = (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;
  assign good    = (c_reg == (d_reg ^ CHECKSUM_KEY));

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    d_next       = d_reg;
    c_next       = c_reg;
    unsol_next   = unsol_reg;
    data_next    = data_reg;
    packet_next  = packet_reg;
    valid_next   = 1'b0;
    cksum_next   = 1'b0;
    frame_next   = 1'b0;
    timeout_next = 1'b0;
`ifdef RECEPTOR_ALARM_EN
    alarm_next   = 1'b0;
`endif
    if (i_start) begin
      // A new request always restarts the window, whatever was in flight.
      state_next = S_WAIT_FIRST;
      cnt_next   = 32'd0;
      unsol_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
`ifdef RECEPTOR_ALARM_EN
          if (i_rx_dv) begin
            d_next     = i_rx_byte;
            unsol_next = 1'b1;
            cnt_next   = 32'd0;
            state_next = S_WAIT_SECOND;
          end
`endif
        end
        S_WAIT_FIRST: begin
          if (i_rx_dv) begin
            d_next     = i_rx_byte;
            cnt_next   = 32'd0;
            state_next = S_WAIT_SECOND;
          end else if (cnt_reg >= TIMEOUT_LAST) begin
            timeout_next = 1'b1;
            state_next   = S_IDLE;
          end else begin
            cnt_next = cnt_sat;
          end
        end
        S_WAIT_SECOND: begin
          if (i_rx_dv) begin
            c_next     = i_rx_byte;
            state_next = S_CHECK;
          end else if (cnt_reg >= GAP_LAST) begin
            frame_next = !unsol_reg;
            state_next = S_IDLE;
          end else begin
            cnt_next = cnt_sat;
          end
        end
        default: begin
          if (unsol_reg) begin
`ifdef RECEPTOR_ALARM_EN
            if (good) begin
              alarm_next  = 1'b1;
              data_next   = d_reg;
              packet_next = {c_reg, d_reg};
            end
`endif
          end else begin
            valid_next  = good;
            cksum_next  = !good;
            data_next   = d_reg;
            packet_next = {c_reg, d_reg};
          end
          state_next = S_IDLE;
        end
      endcase
    end
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 32'd0;
      d_reg       <= 8'h00;
      c_reg       <= 8'h00;
      unsol_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      data_reg    <= 8'h00;
      packet_reg  <= 16'h0000;
      valid_reg   <= 1'b0;
      cksum_reg   <= 1'b0;
      frame_reg   <= 1'b0;
      timeout_reg <= 1'b0;
`ifdef RECEPTOR_ALARM_EN
      alarm_reg   <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      d_reg       <= d_next;
      c_reg       <= c_next;
      unsol_reg   <= unsol_next;
      busy_reg    <= busy_next;
      data_reg    <= data_next;
      packet_reg  <= packet_next;
      valid_reg   <= valid_next;
      cksum_reg   <= cksum_next;
      frame_reg   <= frame_next;
      timeout_reg <= timeout_next;
`ifdef RECEPTOR_ALARM_EN
      alarm_reg   <= alarm_next;
`endif
    end
  end

  assign o_busy      = busy_reg;
  assign o_data      = data_reg;
  assign o_packet    = packet_reg;
  assign o_valid     = valid_reg;
  assign o_cksum_err = cksum_reg;
  assign o_frame_err = frame_reg;
  assign o_timeout   = timeout_reg;
`ifdef RECEPTOR_ALARM_EN
  assign o_alarm     = alarm_reg;
`else
  assign o_alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_pacote.sv
// Self-checking bench for receptor_pacote: directed table, multi-cycle corner sequences and
// randomized traffic compared every cycle against a deadline-based reference model.
module tb_receptor_pacote;
  localparam int unsigned T   = 100;
  localparam int unsigned G   = 50;
  localparam logic [7:0]  KEY = 8'h37;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_rx_dv = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        o_busy, o_valid, o_cksum_err, o_frame_err, o_timeout, o_alarm;
  logic [7:0]  o_data;
  logic [15:0] o_packet;

  always #5 clock = ~clock;

  receptor_pacote #(.CLKS_TIMEOUT(T), .CLKS_BYTE_GAP(G), .CHECKSUM_KEY(KEY)) dut (
    .clock(clock), .reset(reset), .i_start(i_start), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_busy(o_busy), .o_data(o_data), .o_packet(o_packet), .o_valid(o_valid),
    .o_cksum_err(o_cksum_err), .o_frame_err(o_frame_err), .o_timeout(o_timeout), .o_alarm(o_alarm)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase plus an absolute deadline edge number instead of a running counter.
  int          m_phase = 0;   // 0 idle, 1 awaiting data, 2 awaiting check, 3 checking
  longint      edge_no = 0;
  longint      deadline = 0;
  logic [7:0]  m_d = 8'h00, m_c = 8'h00;
  logic        m_unsol = 1'b0;
  logic        e_busy = 0, e_valid = 0, e_cksum = 0, e_frame = 0, e_timeout = 0, e_alarm = 0;
  logic [7:0]  e_data = 8'h00;
  logic [15:0] e_packet = 16'h0000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic dv, input logic [7:0] b);
    edge_no++;
    e_valid = 0; e_cksum = 0; e_frame = 0; e_timeout = 0; e_alarm = 0;
    if (!rst) begin
      m_phase = 0; m_unsol = 0; e_data = 8'h00; e_packet = 16'h0000;
    end else if (st) begin
      m_phase = 1; deadline = edge_no + T; m_unsol = 0;
    end else begin
      case (m_phase)
        0: begin
`ifdef RECEPTOR_ALARM_EN
          if (dv) begin m_d = b; m_unsol = 1; m_phase = 2; deadline = edge_no + G; end
`endif
        end
        1: begin
          if (dv) begin m_d = b; m_phase = 2; deadline = edge_no + G; end
          else if (edge_no == deadline) begin e_timeout = 1; m_phase = 0; end
        end
        2: begin
          if (dv) begin m_c = b; m_phase = 3; end
          else if (edge_no == deadline) begin e_frame = !m_unsol; m_phase = 0; end
        end
        default: begin
          if (m_unsol) begin
            if (m_c == (m_d ^ KEY)) begin e_alarm = 1; e_data = m_d; e_packet = {m_c, m_d}; end
          end else begin
            e_data = m_d; e_packet = {m_c, m_d};
            if (m_c == (m_d ^ KEY)) e_valid = 1; else e_cksum = 1;
          end
          m_phase = 0;
        end
      endcase
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic cyc(input logic rst, input logic st, input logic dv, input logic [7:0] b);
    reset = rst; i_start = st; i_rx_dv = dv; i_rx_byte = b;
    @(posedge clock);
    model_edge(rst, st, dv, b);
    @(negedge clock);
    chk("busy", 16'(o_busy), 16'(e_busy));
    chk("data", 16'(o_data), 16'(e_data));
    chk("packet", o_packet, e_packet);
    chk("valid", 16'(o_valid), 16'(e_valid));
    chk("cksum_err", 16'(o_cksum_err), 16'(e_cksum));
    chk("frame_err", 16'(o_frame_err), 16'(e_frame));
    chk("timeout", 16'(o_timeout), 16'(e_timeout));
    chk("alarm", 16'(o_alarm), 16'(e_alarm));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   seen, pulses;
    logic [7:0] prev_data, last_b, b;
    logic rst, st, dv;

    tbl[0] = '{8'h19, 8'h2E, 1'b1, 1'b0};
    tbl[1] = '{8'h19, 8'h2F, 1'b0, 1'b1};
    tbl[2] = '{8'h05, 8'h32, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h37, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 8'hC8, 1'b1, 1'b0};
    tbl[5] = '{8'hAA, 8'h00, 1'b0, 1'b1};

    // Reset held low with i_start asserted must keep everything at zero.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("reset_busy", 16'(o_busy), 16'h0);
    chk("reset_packet", o_packet, 16'h0000);
    $display("txn reset: busy=%b data=%h packet=%h", o_busy, o_data, o_packet);
    idle(2);

    foreach (tbl[k]) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      chk("tbl_busy_armed", 16'(o_busy), 16'h1);
      cyc(1'b1, 1'b0, 1'b1, tbl[k].d);
      cyc(1'b1, 1'b0, 1'b1, tbl[k].c);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("tbl_valid", 16'(o_valid), 16'(tbl[k].exp_valid));
      chk("tbl_cksum_err", 16'(o_cksum_err), 16'(tbl[k].exp_err));
      chk("tbl_data", 16'(o_data), 16'(tbl[k].d));
      chk("tbl_packet", o_packet, {tbl[k].c, tbl[k].d});
      chk("tbl_busy_done", 16'(o_busy), 16'h0);
      $display("txn table %0d: d=%h c=%h valid=%b cksum_err=%b", k, tbl[k].d, tbl[k].c, o_valid, o_cksum_err);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("tbl_pulse_width", 16'({o_valid, o_cksum_err}), 16'h0);
    end

    // Timeout with no bytes: pulse on the 100th cycle after arming, once.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    seen = -1; pulses = 0;
    for (int i = 1; i <= 110; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      if (o_timeout) begin pulses++; if (seen < 0) seen = i; end
    end
    chk("timeout_cycle", 16'(seen), 16'd100);
    chk("timeout_count", 16'(pulses), 16'd1);
    $display("txn timeout: pulse at cycle %0d, count %0d", seen, pulses);

    // Byte arriving on the expiry edge wins over the timeout.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    idle(99);
    cyc(1'b1, 1'b0, 1'b1, 8'h19);
    chk("late_byte_no_timeout", 16'(o_timeout), 16'h0);
    chk("late_byte_busy", 16'(o_busy), 16'h1);
    cyc(1'b1, 1'b0, 1'b1, 8'h2E);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("late_byte_valid", 16'(o_valid), 16'h1);
    $display("txn boundary byte: valid=%b data=%h", o_valid, o_data);

    // Gap expiry after first byte, then a clean packet.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h19);
    seen = -1; pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      if (o_frame_err) begin pulses++; if (seen < 0) seen = i; end
    end
    chk("frame_err_cycle", 16'(seen), 16'd50);
    chk("frame_err_count", 16'(pulses), 16'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h05);
    cyc(1'b1, 1'b0, 1'b1, 8'h32);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("after_frame_valid", 16'(o_valid), 16'h1);
    chk("after_frame_data", 16'(o_data), 16'h05);
    $display("txn frame error then packet: frame pulses=%0d valid=%b data=%h", pulses, o_valid, o_data);

    // Reset between the two bytes abandons the frame silently.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h19);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h2E);
    idle(3);
    chk("midreset_busy", 16'(o_busy), 16'h0);
    chk("midreset_quiet", 16'({o_valid, o_cksum_err, o_frame_err, o_timeout}), 16'h0);
    $display("txn reset mid-frame: busy=%b", o_busy);

    // Restart mid-frame discards the partial data byte.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h19);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h05);
    cyc(1'b1, 1'b0, 1'b1, 8'h32);
    cyc(1'b1, 1'b0, 1'b1, 8'h77);   // strobe during CHECK is dropped
    chk("restart_valid", 16'(o_valid), 16'h1);
    chk("restart_data", 16'(o_data), 16'h05);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("check_drop_busy", 16'(o_busy), 16'h0);
    $display("txn restart: valid=%b data=%h", o_valid, o_data);

    // Unsolicited packet.
    prev_data = o_data;
    cyc(1'b1, 1'b0, 1'b1, 8'h05);
    cyc(1'b1, 1'b0, 1'b1, 8'h32);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef RECEPTOR_ALARM_EN
    chk("unsol_alarm", 16'(o_alarm), 16'h1);
    chk("unsol_no_valid", 16'(o_valid), 16'h0);
    chk("unsol_data", 16'(o_data), 16'h05);
`else
    chk("unsol_quiet", 16'({o_alarm, o_valid, o_busy}), 16'h0);
    chk("unsol_data_held", 16'(o_data), 16'(prev_data));
`endif
    $display("txn unsolicited: alarm=%b valid=%b data=%h", o_alarm, o_valid, o_data);

    // Randomized traffic against the model.
    last_b = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) != 0);
      st  = ($urandom_range(0, 149) == 0);
      dv  = ($urandom_range(0, 24) == 0);
      b   = ($urandom_range(0, 1) == 1) ? (last_b ^ KEY) : 8'($urandom_range(0, 255));
      if (dv) last_b = b;
      cyc(rst, st, dv, b);
    end
    $display("txn random: 4000 cycles done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
